// File: rtl/piso_frame_serializer_if.sv
// Load handshake and serial status bundle between an upstream word source and the serializer.
interface piso_frame_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  out;
  logic                  busy;
  logic                  done;

  modport master (
    output load_valid, load_data,
    input  load_ready, out, busy, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, out, busy, done
  );
endinterface

// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out word serializer with optional start/stop framing, feeding a SISO register.
module piso_frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 1,
  parameter int MSB_FIRST  = 0,
  parameter int FRAME_EN   = 0,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input logic                     CLK,
  input logic                     RST,
  piso_frame_serializer_if.slave  bus
);
  localparam int CNT_W  = $clog2(DATA_WIDTH);
  localparam int BAUD_W = $clog2(BIT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SHIFT = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic                  out_q, out_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  baud_last;

  assign baud_last = (baud_cnt_q == BAUD_W'(BIT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      out_q      <= IDLE_LEVEL;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    out_d      = out_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        out_d   = IDLE_LEVEL;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (bus.load_valid && ready_q) begin
          sreg_d     = bus.load_data;
          bit_cnt_d  = '0;
          baud_cnt_d = '0;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
          if (FRAME_EN != 0) begin
            state_d = ST_START;
            out_d   = 1'b0;
          end else begin
            state_d = ST_SHIFT;
            out_d   = (MSB_FIRST != 0) ? bus.load_data[DATA_WIDTH-1] : bus.load_data[0];
          end
        end
      end

      ST_START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = ST_SHIFT;
          out_d      = (MSB_FIRST != 0) ? sreg_q[DATA_WIDTH-1] : sreg_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      ST_SHIFT: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            if (FRAME_EN != 0) begin
              state_d = ST_STOP;
              out_d   = 1'b1;
            end else begin
              state_d = ST_IDLE;
              out_d   = IDLE_LEVEL;
              busy_d  = 1'b0;
              ready_d = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            // The bit being driven always sits at the shift-out end of sreg.
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (MSB_FIRST != 0) begin
              sreg_d = {sreg_q[DATA_WIDTH-2:0], 1'b0};
              out_d  = sreg_q[DATA_WIDTH-2];
            end else begin
              sreg_d = {1'b0, sreg_q[DATA_WIDTH-1:1]};
              out_d  = sreg_q[1];
            end
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = ST_IDLE;
          out_d      = IDLE_LEVEL;
          busy_d     = 1'b0;
          ready_d    = 1'b1;
          done_d     = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.out        = out_q;
  assign bus.busy       = busy_q;
  assign bus.load_ready = ready_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed bench: three serializer configurations plus a behavioural 8-bit SISO register model.
module tb_piso_frame_serializer;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] siso = '0;

  always #5 CLK = ~CLK;

  piso_frame_serializer_if #(.DATA_WIDTH(8)) if0 ();
  piso_frame_serializer_if #(.DATA_WIDTH(8)) if1 ();
  piso_frame_serializer_if #(.DATA_WIDTH(8)) if2 ();

  piso_frame_serializer #(.DATA_WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(0), .FRAME_EN(0), .IDLE_LEVEL(1'b1))
    u_lsb (.CLK(CLK), .RST(RST), .bus(if0));
  piso_frame_serializer #(.DATA_WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1), .FRAME_EN(1), .IDLE_LEVEL(1'b1))
    u_msbf (.CLK(CLK), .RST(RST), .bus(if1));
  piso_frame_serializer #(.DATA_WIDTH(8), .BIT_CYCLES(3), .MSB_FIRST(0), .FRAME_EN(0), .IDLE_LEVEL(1'b1))
    u_slow (.CLK(CLK), .RST(RST), .bus(if2));

  // SISO register downstream of u_lsb: serial in enters Q0, oldest bit ends up in Q7.
  always @(posedge CLK) siso <= {siso[6:0], if0.out};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] taps_q0_to_q7(input logic [7:0] s);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = s[7-k];
    return r;
  endfunction

  int seq_a5[8]   = '{1, 0, 1, 0, 0, 1, 0, 1};
  int seq_5a[8]   = '{0, 1, 0, 1, 1, 0, 1, 0};
  int seq_3c_f[10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};

  initial begin
    int dones;
    if0.load_valid = 1'b0; if0.load_data = '0;
    if1.load_valid = 1'b0; if1.load_data = '0;
    if2.load_valid = 1'b0; if2.load_data = '0;

    // Power-on reset state
    tick(); tick();
    RST = 1'b0;
    chk("rst_out",   32'(if0.out),        32'd1);
    chk("rst_busy",  32'(if0.busy),       32'd0);
    chk("rst_ready", 32'(if0.load_ready), 32'd1);
    chk("rst_done",  32'(if0.done),       32'd0);

    // Basic LSB-first 8'hA5; data bus changed after accept must not matter
    if0.load_valid = 1'b1; if0.load_data = 8'hA5;
    tick();
    if0.load_valid = 1'b0; if0.load_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_out%0d", i), 32'(if0.out), 32'(seq_a5[i]));
      chk($sformatf("a5_busy%0d", i), 32'(if0.busy), 32'd1);
      chk($sformatf("a5_done%0d", i), 32'(if0.done), 32'd0);
      chk($sformatf("a5_rdy%0d", i), 32'(if0.load_ready), 32'd0);
      tick();
    end
    chk("a5_end_out",  32'(if0.out),        32'd1);
    chk("a5_end_done", 32'(if0.done),       32'd1);
    chk("a5_end_rdy",  32'(if0.load_ready), 32'd1);
    chk("a5_end_busy", 32'(if0.busy),       32'd0);
    tick();
    chk("a5_done_1cyc", 32'(if0.done), 32'd0);

    // MSB-first with framing, 8'h3C
    if1.load_valid = 1'b1; if1.load_data = 8'h3C;
    tick();
    if1.load_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("3c_out%0d", i), 32'(if1.out), 32'(seq_3c_f[i]));
      chk($sformatf("3c_done%0d", i), 32'(if1.done), 32'd0);
      tick();
    end
    chk("3c_end_done", 32'(if1.done), 32'd1);
    chk("3c_end_out",  32'(if1.out),  32'd1);

    // BIT_CYCLES=3, 8'h01
    if2.load_valid = 1'b1; if2.load_data = 8'h01;
    tick();
    if2.load_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      chk($sformatf("slow_out%0d", c), 32'(if2.out), (c < 3) ? 32'd1 : 32'd0);
      chk($sformatf("slow_done%0d", c), 32'(if2.done), 32'd0);
      tick();
    end
    chk("slow_end_done", 32'(if2.done), 32'd1);
    chk("slow_end_out",  32'(if2.out),  32'd1);
    tick();

    // Busy rejection: 8'hFF offered mid-frame of 8'h00
    if0.load_valid = 1'b1; if0.load_data = 8'h00;
    tick();
    if0.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rej_out%0d", i), 32'(if0.out), 32'd0);
      if (i == 2) begin
        if0.load_valid = 1'b1; if0.load_data = 8'hFF;
      end else begin
        if0.load_valid = 1'b0;
      end
      tick();
    end
    chk("rej_done", 32'(if0.done), 32'd1);
    tick();
    chk("rej_no_restart", 32'(if0.busy), 32'd0);
    tick();

    // Streaming A5 then 5A with load_valid held high
    dones = 0;
    if0.load_valid = 1'b1; if0.load_data = 8'hA5;
    tick();
    if0.load_data = 8'h5A;
    for (int c = 1; c <= 20; c++) begin
      if (if0.done) dones++;
      if (c <= 8) chk($sformatf("st_a5_out%0d", c), 32'(if0.out), 32'(seq_a5[c-1]));
      else if (c == 9) begin
        chk("st_done1", 32'(if0.done), 32'd1);
        chk("st_siso_a5", 32'(taps_q0_to_q7(siso)), 32'h0A5);
      end else if (c <= 17) chk($sformatf("st_5a_out%0d", c), 32'(if0.out), 32'(seq_5a[c-10]));
      else if (c == 18) begin
        chk("st_done2", 32'(if0.done), 32'd1);
        chk("st_siso_5a", 32'(taps_q0_to_q7(siso)), 32'h05A);
      end
      if (c == 10) chk("st_gap_busy", 32'(if0.busy), 32'd1);
      if (c == 10) if0.load_valid = 1'b0;
      tick();
    end
    chk("st_done_count", 32'(dones), 32'd2);

    // Reset mid-frame: abandoned frame, no done pulse
    if0.load_valid = 1'b1; if0.load_data = 8'h00;
    tick();
    if0.load_valid = 1'b0;
    tick(); tick();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    chk("mid_rst_out",   32'(if0.out),        32'd1);
    chk("mid_rst_busy",  32'(if0.busy),       32'd0);
    chk("mid_rst_ready", 32'(if0.load_ready), 32'd1);
    chk("mid_rst_done",  32'(if0.done),       32'd0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (if0.done) dones++;
      tick();
    end
    chk("mid_rst_no_done", 32'(dones), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
